// File: rtl/mod_sinebank.sv
// Time-multiplexed N-channel oscillator bank: per-channel phase/inc/mode registers
// feeding one shared iterative CORDIC; one frame request yields N samples in channel order.
module mod_sinebank #(
  parameter int unsigned N_CHANNELS = 4,
  parameter int unsigned PHASE_W    = 32,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned ITER       = 16,
  localparam int unsigned CH_W      = $clog2(N_CHANNELS)
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_sample,
  input  logic               i_cfg_we,
  input  logic [CH_W-1:0]    i_cfg_ch,
  input  logic [PHASE_W-1:0] i_cfg_inc,
  input  logic [1:0]         i_cfg_mode,
  input  logic               i_cfg_rst_phase,
  output logic [OUT_W-1:0]   o_sample,
  output logic [CH_W-1:0]    o_ch,
  output logic               o_valid,
  output logic               o_frame_done,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam int unsigned XY_W  = OUT_W + 2;
  localparam int unsigned IT_W  = $clog2(ITER);
  localparam int          AMP_I = (1 << (OUT_W - 1)) - 1;
  localparam int          X0_I  = $rtoi(0.6072529350 * AMP_I + 0.5);
  localparam logic signed [XY_W-1:0] AMP     = XY_W'(AMP_I);
  localparam logic signed [XY_W-1:0] NEG_AMP = -XY_W'(AMP_I);
  localparam logic signed [XY_W-1:0] X_INIT  = XY_W'(X0_I);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROT, S_OUT} state_e;

  // atan(2^-i) as a fraction of a full turn, 32-bit scale, rescaled to PHASE_W
  function automatic logic [PHASE_W-1:0] atan_lut(input logic [31:0] i);
    logic [31:0] v;
    logic [63:0] w;
    case (i)
      0: v = 32'd536870912;   1: v = 32'd316933406;   2: v = 32'd167458907;
      3: v = 32'd85004756;    4: v = 32'd42667331;    5: v = 32'd21354465;
      6: v = 32'd10680862;    7: v = 32'd5340245;     8: v = 32'd2670163;
      9: v = 32'd1335087;    10: v = 32'd667544;     11: v = 32'd333772;
     12: v = 32'd166886;     13: v = 32'd83443;      14: v = 32'd41722;
     15: v = 32'd20861;      16: v = 32'd10430;      17: v = 32'd5215;
     18: v = 32'd2608;       19: v = 32'd1304;       20: v = 32'd652;
     21: v = 32'd326;        22: v = 32'd163;        23: v = 32'd81;
     24: v = 32'd41;         25: v = 32'd20;         26: v = 32'd10;
     27: v = 32'd5;          28: v = 32'd3;          29: v = 32'd1;
     30: v = 32'd1;
      default: v = 32'd0;
    endcase
    w = {v, 32'd0};
    return PHASE_W'(w >> (64 - PHASE_W));
  endfunction

  state_e                     state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [IT_W-1:0]            iter_q, iter_d;
  logic signed [XY_W-1:0]     x_q, x_d, y_q, y_d;
  logic signed [PHASE_W-1:0]  z_q, z_d;
  logic [PHASE_W-1:0]         p_q, p_d;
  logic [1:0]                 lmode_q, lmode_d;
  logic [PHASE_W-1:0]         phase_q [N_CHANNELS];
  logic [PHASE_W-1:0]         phase_d [N_CHANNELS];
  logic [PHASE_W-1:0]         inc_q   [N_CHANNELS];
  logic [PHASE_W-1:0]         inc_d   [N_CHANNELS];
  logic [1:0]                 mode_q  [N_CHANNELS];
  logic [1:0]                 mode_d  [N_CHANNELS];
  logic [OUT_W-1:0]           sample_q, sample_d;
  logic [CH_W-1:0]            och_q, och_d;
  logic                       valid_q, valid_d, fdone_q, fdone_d;
  logic                       busy_q, busy_d, overrun_q, overrun_d;

  logic signed [XY_W-1:0]     xs_c, ys_c, x_n_c, y_n_c, rot_c, sine_c;
  logic signed [PHASE_W-1:0]  z_n_c;
  logic [PHASE_W-1:0]         atan_c;
  logic [OUT_W-1:0]           slot_c;
  logic                       last_ch_c;

  // One CORDIC micro-rotation plus quadrant fold and saturation of its result
  always_comb begin
    atan_c = atan_lut(32'(iter_q));
    xs_c   = x_q >>> iter_q;
    ys_c   = y_q >>> iter_q;
    if (!z_q[PHASE_W-1]) begin
      x_n_c = x_q - ys_c;
      y_n_c = y_q + xs_c;
      z_n_c = z_q - $signed(atan_c);
    end else begin
      x_n_c = x_q + ys_c;
      y_n_c = y_q - xs_c;
      z_n_c = z_q + $signed(atan_c);
    end
    case (p_q[PHASE_W-1 -: 2])
      2'd0:    rot_c = y_n_c;
      2'd1:    rot_c = x_n_c;
      2'd2:    rot_c = -y_n_c;
      default: rot_c = -x_n_c;
    endcase
    if (rot_c > AMP)          sine_c = AMP;
    else if (rot_c < NEG_AMP) sine_c = NEG_AMP;
    else                      sine_c = rot_c;
    case (lmode_q)
      2'd0:    slot_c = OUT_W'(sine_c);
      2'd1:    slot_c = p_q[PHASE_W-1] ? OUT_W'(NEG_AMP) : OUT_W'(AMP);
      2'd2:    slot_c = {~p_q[PHASE_W-1], p_q[PHASE_W-2 -: OUT_W-1]};
      default: slot_c = '0;
    endcase
    last_ch_c = (ch_q == CH_W'(N_CHANNELS - 1));
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    iter_d    = iter_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    p_d       = p_q;
    lmode_d   = lmode_q;
    phase_d   = phase_q;
    inc_d     = inc_q;
    mode_d    = mode_q;
    sample_d  = sample_q;
    och_d     = och_q;
    valid_d   = 1'b0;
    fdone_d   = 1'b0;
    overrun_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_sample) begin
          state_d = S_LOAD;
          ch_d    = '0;
        end
      end
      S_LOAD: begin
        p_d     = phase_q[ch_q];
        lmode_d = mode_q[ch_q];
        x_d     = X_INIT;
        y_d     = '0;
        z_d     = $signed({2'b00, phase_q[ch_q][PHASE_W-3:0]});
        iter_d  = '0;
        state_d = S_ROT;
      end
      S_ROT: begin
        x_d    = x_n_c;
        y_d    = y_n_c;
        z_d    = z_n_c;
        iter_d = iter_q + IT_W'(1);
        // Sample is registered on the same edge as the final rotation
        if (iter_q == IT_W'(ITER - 1)) begin
          state_d  = S_OUT;
          sample_d = slot_c;
          och_d    = ch_q;
          valid_d  = 1'b1;
          fdone_d  = last_ch_c;
        end
      end
      S_OUT: begin
        phase_d[ch_q] = phase_q[ch_q] + inc_q[ch_q];
        if (last_ch_c) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_LOAD;
          ch_d    = ch_q + CH_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (i_sample && (state_q != S_IDLE)) overrun_d = 1'b1;

    // Applied after the OUT advance so a same-cycle phase clear wins
    if (i_cfg_we && (32'(i_cfg_ch) < N_CHANNELS)) begin
      inc_d[i_cfg_ch]  = i_cfg_inc;
      mode_d[i_cfg_ch] = i_cfg_mode;
      if (i_cfg_rst_phase) phase_d[i_cfg_ch] = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      iter_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      p_q       <= '0;
      lmode_q   <= '0;
      for (int i = 0; i < int'(N_CHANNELS); i++) begin
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
        mode_q[i]  <= '0;
      end
      sample_q  <= '0;
      och_q     <= '0;
      valid_q   <= 1'b0;
      fdone_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      iter_q    <= iter_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      p_q       <= p_d;
      lmode_q   <= lmode_d;
      phase_q   <= phase_d;
      inc_q     <= inc_d;
      mode_q    <= mode_d;
      sample_q  <= sample_d;
      och_q     <= och_d;
      valid_q   <= valid_d;
      fdone_q   <= fdone_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_sample     = sample_q;
  assign o_ch         = och_q;
  assign o_valid      = valid_q;
  assign o_frame_done = fdone_q;
  assign o_busy       = busy_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_mod_sinebank.sv
// Directed bench for mod_sinebank: a behavioural phase/waveform model queues expected
// samples per frame; a negedge monitor pops and compares each o_valid beat.
module tb_mod_sinebank;

  localparam int N     = 4;
  localparam int S     = 18;
  localparam int FRAME = N * S;
  localparam int A     = 32767;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        sample = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [31:0] cfg_inc = '0;
  logic [1:0]  cfg_mode = '0;
  logic        cfg_rst = 1'b0;
  logic [15:0] o_sample;
  logic [1:0]  o_ch;
  logic        o_valid, o_frame_done, o_busy, o_overrun;

  mod_sinebank dut (
    .i_clk(clk), .i_nrst(nrst), .i_sample(sample),
    .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch), .i_cfg_inc(cfg_inc),
    .i_cfg_mode(cfg_mode), .i_cfg_rst_phase(cfg_rst),
    .o_sample(o_sample), .o_ch(o_ch), .o_valid(o_valid),
    .o_frame_done(o_frame_done), .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int at; int ch; int val; int tol; bit fd; } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  longint unsigned m_phase [N];
  longint unsigned m_inc   [N];
  int              m_mode  [N];

  function automatic int model_out(input int mode, input longint unsigned p);
    real ang;
    int  top;
    case (mode)
      0: begin
        ang = 2.0 * 3.14159265358979 * real'(p) / 4294967296.0;
        return $rtoi($floor(32767.0 * $sin(ang) + 0.5));
      end
      1: return (p >= 64'h8000_0000) ? -A : A;
      2: begin
        top = int'(p >> 16);
        return top - 32768;
      end
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int expv, input int tol);
    checks++;
    assert ((obs - expv <= tol) && (expv - obs <= tol)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
    end
  endtask

  task automatic goto(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_phase[c] = 0;
      m_inc[c]   = 0;
      m_mode[c]  = 0;
    end
  endtask

  // Advance every channel whose bit in skip is clear
  task automatic advance_model(input bit [N-1:0] skip);
    for (int c = 0; c < N; c++)
      if (!skip[c]) m_phase[c] = (m_phase[c] + m_inc[c]) & 64'hFFFF_FFFF;
  endtask

  task automatic cfg(input int ch, input longint unsigned inc, input int mode, input bit rp);
    int k;
    k        = cyc;
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_inc  = 32'(inc);
    cfg_mode = 2'(mode);
    cfg_rst  = rp;
    m_inc[ch]  = inc;
    m_mode[ch] = mode;
    if (rp) m_phase[ch] = 0;
    goto(k + 1);
    cfg_we  = 1'b0;
    cfg_rst = 1'b0;
  endtask

  // Requests a frame in the current cycle and queues the first n_exp channel results
  task automatic start_frame(input int n_exp, output int t0);
    exp_t e;
    t0 = cyc;
    sample = 1'b1;
    for (int c = 0; c < n_exp; c++) begin
      e.at  = t0 + (c + 1) * S;
      e.ch  = c;
      e.val = model_out(m_mode[c], m_phase[c]);
      e.tol = (m_mode[c] == 0) ? 4 : 0;
      e.fd  = (c == N - 1);
      sb.push_back(e);
    end
    goto(t0 + 1);
    sample = 1'b0;
  endtask

  task automatic finish_frame(input int t0, input string tag);
    goto(t0 + FRAME + 1);
    chk({tag, "_drain"}, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_valid) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_valid observed=valid at cycle %0d ch %0d expected=no valid", cyc, o_ch);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("valid_cycle", cyc, e.at);
        chk("valid_ch", int'(o_ch), e.ch);
        chk("frame_done", int'(o_frame_done), int'(e.fd));
        chk_near($sformatf("sample_ch%0d", e.ch), int'($signed(o_sample)), e.val, e.tol);
      end
    end else if (o_frame_done) begin
      chk("frame_done_without_valid", int'(o_frame_done), 0);
    end
  end

  initial begin
    int t0;
    model_reset();

    // Reset state
    goto(3);
    chk("rst_sample", int'(o_sample), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_overrun", int'(o_overrun), 0);
    chk("rst_frame_done", int'(o_frame_done), 0);
    nrst = 1'b1;
    goto(5);

    // Default frame: all channels sine at phase 0, plus busy window edges
    start_frame(N, t0);
    chk("busy_first", int'(o_busy), 1);
    goto(t0 + FRAME);
    chk("busy_last", int'(o_busy), 1);
    goto(t0 + FRAME + 1);
    chk("busy_idle", int'(o_busy), 0);
    finish_frame(t0, "default");
    advance_model('0);

    // Quarter-turn sine, square, saw, off over four frames
    cfg(0, 64'h4000_0000, 0, 1'b1);
    cfg(1, 64'h8000_0000, 1, 1'b1);
    cfg(2, 64'h1000_0000, 2, 1'b1);
    cfg(3, 64'h0000_0000, 3, 1'b1);
    for (int f = 0; f < 4; f++) begin
      start_frame(N, t0);
      finish_frame(t0, "quarter");
      advance_model('0);
    end

    // 45 degree sine on ch0
    cfg(0, 64'h2000_0000, 0, 1'b1);
    for (int f = 0; f < 2; f++) begin
      start_frame(N, t0);
      finish_frame(t0, "eighth");
      advance_model('0);
    end

    // Overrun request mid-frame, then back-to-back accept at the earliest cycle
    start_frame(N, t0);
    goto(t0 + 40);
    sample = 1'b1;
    goto(t0 + 41);
    sample = 1'b0;
    chk("overrun_pulse", int'(o_overrun), 1);
    goto(t0 + 42);
    chk("overrun_clear", int'(o_overrun), 0);
    goto(t0 + FRAME + 1);
    chk("overrun_drain", sb.size(), 0);
    advance_model('0);
    start_frame(N, t0);
    chk("accept_no_overrun", int'(o_overrun), 0);
    finish_frame(t0, "back2back");
    advance_model('0);

    // Config/OUT collisions: ch0 phase clear during its OUT, ch3 inc change mid-frame
    cfg(3, 64'h1000_0000, 2, 1'b1);
    start_frame(N, t0);
    goto(t0 + S);
    cfg(0, 64'h2000_0000, 0, 1'b1);
    goto(t0 + 30);
    cfg(3, 64'h4000_0000, 2, 1'b0);
    finish_frame(t0, "collision");
    advance_model(4'b0001);
    start_frame(N, t0);
    finish_frame(t0, "after_collision");
    advance_model('0);

    // Write during ch0 rotation leaves the in-flight sample alone
    start_frame(N, t0);
    goto(t0 + 5);
    cfg(0, 64'h0, 3, 1'b0);
    finish_frame(t0, "inflight");
    advance_model('0);
    start_frame(N, t0);
    finish_frame(t0, "after_inflight");
    advance_model('0);

    // Reset mid-frame: only ch0 completes, then state returns to defaults
    cfg(0, 64'h4000_0000, 0, 1'b0);
    start_frame(1, t0);
    goto(t0 + 30);
    nrst = 1'b0;
    goto(t0 + 31);
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_sample", int'(o_sample), 0);
    chk("midrst_valid", int'(o_valid), 0);
    nrst = 1'b1;
    model_reset();
    goto(t0 + 100);
    chk("midrst_drain", sb.size(), 0);
    for (int f = 0; f < 2; f++) begin
      start_frame(N, t0);
      finish_frame(t0, "post_reset");
      advance_model('0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_sinebank.md
# mod_sinebank

Multi-channel, time-multiplexed oscillator bank that generalises the single-channel sine source. Each channel keeps its own phase accumulator, phase increment and waveform mode. A single iterative CORDIC engine, shared by all channels, produces one signed sample per channel for every frame request. The block sits between the sample-rate tick generator and the mixer/voice stage: one `i_sample` strobe yields N channel samples streamed out in channel order.

## Interface
- `N_CHANNELS`, 4: number of channels, ≥2; `CH_W = $clog2(N_CHANNELS)`
- `PHASE_W`, 32: phase accumulator / increment width; full scale = one period
- `OUT_W`, 16: output sample width, signed
- `ITER`, 16: CORDIC iterations per sample; ≥ `OUT_W`
- `i_clk` in 1: single clock; all logic rising-edge
- `i_nrst` in 1: reset, synchronous, active-low
- `i_sample` in 1: frame request strobe
- `i_cfg_we` in 1: config write enable
- `i_cfg_ch` in `CH_W`: channel addressed by the write
- `i_cfg_inc` in `PHASE_W`: phase increment (unsigned) to store
- `i_cfg_mode` in 2: waveform (0 sine, 1 square, 2 saw, 3 off)
- `i_cfg_rst_phase` in 1: with `i_cfg_we`, clear that channel's phase to 0
- `o_sample` out `OUT_W`: signed sample
- `o_ch` out `CH_W`: channel of `o_sample`
- `o_valid` out 1: one-cycle pulse, `o_sample`/`o_ch` valid
- `o_frame_done` out 1: pulses together with last channel's `o_valid`
- `o_busy` out 1: high while FSM not IDLE
- `o_overrun` out 1: one-cycle pulse when `i_sample` is dropped

## Operation
- Amplitude `A = 2^(OUT_W-1)-1`.
- **Reset:** all phases, increments and modes are 0; FSM is IDLE. All outputs are 0.
- **Reset mid-frame:** aborts the frame immediately. No further `o_valid` occurs.
- **FSM states:** IDLE, LOAD, ROT, OUT.
  - IDLE → LOAD when `i_sample`=1; channel counter is set to 0.
  - LOAD → ROT after 1 cycle.
  - ROT → OUT after `ITER` cycles.
  - OUT → LOAD for the next channel, or → IDLE after channel N-1.
- **LOAD:** latch phase `p` of the current channel.
  - Quadrant `q = p[PHASE_W-1:PHASE_W-2]`.
  - Residual `r` = `p` with its top 2 bits cleared.
  - Initialise CORDIC: `x = round(0.6072529350 * A)`, `y = 0`, `z = r`.
  - x and y datapaths are `OUT_W+2` bits signed.
- **ROT iteration i (0..ITER-1):** `d = (z >= 0)`.
  - `x -= d ? y>>>i : -(y>>>i)`
  - `y += d ? x>>>i : -(x>>>i)`, using the pre-update x
  - `z -= d ? atan_i : -atan_i`, where `atan_i = round(atan(2^-i)*2^PHASE_W/(2π))` is held in a constant table.
- **OUT, sine:** result selected by `q`: 0 → y, 1 → x, 2 → -y, 3 → -x. The result is saturated to ±A.
- **OUT, other modes** (these ignore the CORDIC result but still take the same slot time):
  - Square: `p[PHASE_W-1] ? -A : +A`.
  - Saw: top `OUT_W` bits of `p` with the MSB inverted, read as signed. The ramp runs from -2^(OUT_W-1) up to A.
  - Off: 0.
- **OUT, phase advance:** `phase[c] <= phase[c] + inc[c]`, mod 2^PHASE_W, using the `inc` register value in that cycle.
- **Config writes:** accepted in any state and take effect the next cycle.
  - A write to the channel currently in ROT does not affect its in-flight sample. It does affect that channel's phase advance in OUT.
  - A `rst_phase` write in the same cycle as OUT advance for the same channel wins: phase becomes 0.
  - Writes with `i_cfg_ch ≥ N_CHANNELS` are ignored.
- **Overrun:** `i_sample` while `o_busy`=1 is dropped and `o_overrun` pulses on the next cycle.
- **Accuracy:** sine error is ≤ 4 LSB vs `round(A*sin(2π p/2^PHASE_W))`.

## Timing
- `i_sample` is sampled at edge 0. LOAD occupies cycle 1.
- Slot length is `S = ITER+2` cycles.
- Channel c produces `o_valid`=1 in cycle `(c+1)*S`. `o_sample`/`o_ch` are registered and hold until the next OUT.
- `o_frame_done`=1 in cycle `N*S`.
- IDLE is reached in cycle `N*S+1`; `i_sample` is accepted from that cycle on.
- Minimum request period is `N*S+1` cycles.
- `o_busy` is high in cycles 1..`N*S`.
- Defaults: S=18, frame = 72 cycles, next accept at cycle 73.

## Test plan
- **Reset state:** after reset, one `i_sample` with all defaults → 4 `o_valid` pulses at cycles 18, 36, 54, 72 with `o_ch` 0..3, all samples 0, and `o_frame_done` at cycle 72 only.
- **Quarter-turn sine:** ch0 sine, inc=2^30; 4 frames → 0, 32767, 0, -32767 (±4). Use inc=2^29 for 45°: 23170 ±4.
- **Square and saw:** ch1 square, inc=2^31 → +32767, -32767 alternating. ch2 saw, inc=2^28 → -32768, -28672, …, stepping +4096.
- **Overrun:** `i_sample` at cycles 0 and 40 → `o_overrun` pulse at cycle 41 and frame timing unchanged. `i_sample` at cycle 73 → accepted, with ch0 valid at cycle 91.
- **Reset mid-operation:** `i_nrst`=0 at cycle 30 → no `o_valid` after cycle 18; `o_busy`=0 and `o_sample`=0 from cycle 31. Phase of ch0 is 0.
- **Config/OUT collision:** `rst_phase` write to ch0 in cycle 18 → the next frame's ch0 uses phase 0. A write of inc to ch3 during frame → used at cycle 72 advance.
